// File: rtl/store_buffer_pkg.sv
// store_buf_pkg: shared defaults, drain FSM states and pointer-width helper for the store buffer
package store_buf_pkg;
  localparam int SB_DEPTH = 4;
  localparam int SB_AW = 30;
  localparam int SB_DW = 32;
  typedef enum logic {SB_IDLE, SB_WRITE} sb_state_t;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if: CPU store/load, memory write and drain signals; slave = buffer side, master = CPU/memory side
interface store_buffer_if import store_buf_pkg::*; #(parameter int AW = SB_AW, parameter int DW = SB_DW);
  logic st_valid, st_ready;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic [AW-1:0] ld_addr;
  logic ld_hit;
  logic [DW-1:0] ld_data;
  logic mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic drain_req, empty;
  modport master(output st_valid, st_addr, st_data, ld_addr, mem_ack, drain_req,
                 input st_ready, ld_hit, ld_data, mem_we, mem_addr, mem_wdata, empty);
  modport slave(input st_valid, st_addr, st_data, ld_addr, mem_ack, drain_req,
                output st_ready, ld_hit, ld_data, mem_we, mem_addr, mem_wdata, empty);
endinterface

// File: rtl/store_buffer_match.sv
// store_buf_match: load-address lookup over valid entries, youngest (closest to tail) match wins; outputs hit/idx/data
module store_buf_match import store_buf_pkg::*; #(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW = SB_AW,
  parameter int DW = SB_DW,
  parameter int PW = ptr_w(DEPTH)
) (
  input  logic [AW-1:0] addrs [DEPTH],
  input  logic [DW-1:0] datas [DEPTH],
  input  logic [PW-1:0] tail,
  input  logic [PW:0]   count,
  input  logic [AW-1:0] ld_addr,
  output logic          hit,
  output logic [PW-1:0] idx,
  output logic [DW-1:0] data
);
  logic [PW-1:0] j;
  always_comb begin
    hit = 1'b0;
    idx = '0;
    j = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      j = tail - PW'(k + 1);
      if ((PW + 1)'(k) < count && addrs[j] == ld_addr) begin
        hit = 1'b1;
        idx = j;
      end
    end
  end
  assign data = hit ? datas[idx] : '0;
endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO draining to memory with store-to-load forwarding; optional STORE_BUF_COALESCE_EN
module store_buffer import store_buf_pkg::*; #(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW = SB_AW,
  parameter int DW = SB_DW
) (
  input logic CLOCK,
  input logic RESET,
  store_buffer_if.slave bus
);
  localparam int PW = ptr_w(DEPTH);
  logic [AW-1:0] addrs [DEPTH];
  logic [DW-1:0] datas [DEPTH];
  logic [PW-1:0] head, tail, wptr, ld_idx;
  logic [PW:0] count, count_nx;
  sb_state_t state;
  logic enq, deq, merge, alloc;
  assign bus.st_ready = count != (PW + 1)'(DEPTH) && !bus.drain_req;
  assign enq = bus.st_valid && bus.st_ready;
  assign deq = state == SB_WRITE && bus.mem_ack;
`ifdef STORE_BUF_COALESCE_EN
  logic [PW-1:0] last;
  assign last = tail - PW'(1);
  // the in-flight head must not change under the memory, so it is never merged into
  assign merge = enq && count != '0 && addrs[last] == bus.st_addr && !(state == SB_WRITE && last == head);
  assign wptr = merge ? last : tail;
`else
  assign merge = 1'b0;
  assign wptr = tail;
`endif
  assign alloc = enq && !merge;
  assign count_nx = count + (PW + 1)'(alloc) - (PW + 1)'(deq);
  assign bus.empty = count == '0;
  assign bus.mem_we = state == SB_WRITE;
  assign bus.mem_addr = bus.mem_we ? addrs[head] : '0;
  assign bus.mem_wdata = bus.mem_we ? datas[head] : '0;
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      state <= SB_IDLE;
    end else begin
      head <= head + PW'(deq);
      tail <= tail + PW'(alloc);
      count <= count_nx;
      state <= (state == SB_IDLE ? count != '0 : count_nx != '0) ? SB_WRITE : SB_IDLE;
    end
  end
  always_ff @(posedge CLOCK) begin
    if (enq) begin
      addrs[wptr] <= bus.st_addr;
      datas[wptr] <= bus.st_data;
    end
  end
  store_buf_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_match (
    .addrs(addrs),
    .datas(datas),
    .tail(tail),
    .count(count),
    .ld_addr(bus.ld_addr),
    .hit(bus.ld_hit),
    .idx(ld_idx),
    .data(bus.ld_data)
  );
  always_comb if (bus.ld_hit) assert (addrs[ld_idx] == bus.ld_addr);
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed and randomized checks of store_buffer against a queue-based model
module tb_store_buffer;
  import store_buf_pkg::*;
  localparam int DEPTH = 4, AW = 30, DW = 32;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  store_buffer_if #(.AW(AW), .DW(DW)) bus();
  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut(.CLOCK(clk), .RESET(rst), .bus(bus));
  typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} ent_t;
  ent_t q[$];
  ent_t dlog[$];
  bit busy;
  int n_chk, n_fail;
  bit coal;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(posedge clk or posedge rst) begin
    bit acc, pop, mrg;
    int n0;
    if (rst) begin
      q.delete();
      busy = 0;
    end else begin
      n0 = q.size();
      acc = bus.st_valid && n0 < DEPTH && !bus.drain_req;
      pop = busy && bus.mem_ack;
      mrg = coal && acc && n0 != 0 && q[n0-1].a == bus.st_addr && !(busy && n0 == 1);
      if (pop) void'(q.pop_front());
      if (mrg) q[q.size()-1].d = bus.st_data;
      else if (acc) q.push_back('{bus.st_addr, bus.st_data});
      busy = busy ? q.size() != 0 : n0 != 0;
    end
  end
  always @(negedge clk) begin
    bit h;
    logic [DW-1:0] d;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    if (!rst) begin
      h = 0;
      d = '0;
      for (int i = q.size() - 1; i >= 0; i--)
        if (q[i].a == bus.ld_addr) begin
          h = 1;
          d = q[i].d;
          break;
        end
      ea = '0;
      ed = '0;
      if (busy) begin
        ea = q[0].a;
        ed = q[0].d;
      end
      chk("st_ready", bus.st_ready, q.size() < DEPTH && !bus.drain_req);
      chk("empty", bus.empty, q.size() == 0);
      chk("mem_we", bus.mem_we, busy);
      chk("mem_addr", bus.mem_addr, ea);
      chk("mem_wdata", bus.mem_wdata, ed);
      chk("ld_hit", bus.ld_hit, h);
      chk("ld_data", bus.ld_data, d);
      if (bus.mem_we && bus.mem_ack) dlog.push_back('{bus.mem_addr, bus.mem_wdata});
    end
  end
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic set(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit ack, input bit dr, input logic [AW-1:0] la);
    bus.st_valid = v;
    bus.st_addr = a;
    bus.st_data = d;
    bus.mem_ack = ack;
    bus.drain_req = dr;
    bus.ld_addr = la;
  endtask
  task automatic drain_all(input string name);
    int n;
    set(0, 0, 0, 1, 0, 0);
    n = 0;
    while (!bus.empty || bus.mem_we) begin
      tick;
      if (++n > 20) break;
    end
    chk({name, "_drained"}, bus.empty && !bus.mem_we, 1);
  endtask
  initial begin
    int c30;
`ifdef STORE_BUF_COALESCE_EN
    coal = 1;
`else
    coal = 0;
`endif
    set(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_st_ready", bus.st_ready, 1);
    chk("rst_empty", bus.empty, 1);
    chk("rst_ld_hit", bus.ld_hit, 0);
    chk("rst_ld_data", bus.ld_data, 0);
    tick;
    rst = 1'b0;
    tick;
    set(1, 'h10, 32'hDEADBEEF, 1, 0, 'h10);
    tick;
    set(0, 0, 0, 1, 0, 'h10);
    #1;
    chk("t1_we_n", bus.mem_we, 0);
    chk("t1_fwd_hit", bus.ld_hit, 1);
    chk("t1_fwd_data", bus.ld_data, 32'hDEADBEEF);
    tick;
    #1;
    chk("t1_we", bus.mem_we, 1);
    chk("t1_addr", bus.mem_addr, 'h10);
    chk("t1_data", bus.mem_wdata, 32'hDEADBEEF);
    tick;
    #1;
    chk("t1_we_done", bus.mem_we, 0);
    chk("t1_empty", bus.empty, 1);
    for (int i = 0; i < 4; i++) begin
      set(1, AW'('h100 + i), DW'(i + 1), 0, 0, 'h100);
      tick;
    end
    set(1, 'h200, 'h55, 0, 0, 'h100);
    #1;
    chk("t2_full", bus.st_ready, 0);
    chk("t2_fwd", bus.ld_data, 1);
    chk("t2_head", bus.mem_addr, 'h100);
    bus.mem_ack = 1;
    tick;
    bus.mem_ack = 0;
    #1;
    chk("t2_ready_again", bus.st_ready, 1);
    chk("t2_next_head", bus.mem_addr, 'h101);
    tick;
    bus.st_valid = 0;
    bus.ld_addr = 'h200;
    #1;
    chk("t2_full_again", bus.st_ready, 0);
    chk("t2_wrap_hit", bus.ld_hit, 1);
    chk("t2_wrap_data", bus.ld_data, 'h55);
    drain_all("t2");
    set(1, 'h20, 1, 0, 0, 0);
    tick;
    set(1, 'h24, 2, 0, 0, 0);
    tick;
    set(1, 'h20, 3, 0, 0, 0);
    tick;
    set(0, 0, 0, 0, 0, 'h20);
    #1;
    chk("t3_hit", bus.ld_hit, 1);
    chk("t3_data", bus.ld_data, 3);
    bus.ld_addr = 'h28;
    #1;
    chk("t3_miss", bus.ld_hit, 0);
    chk("t3_miss_data", bus.ld_data, 0);
    drain_all("t3");
    dlog.delete();
    set(1, 'h40, 9, 0, 0, 0);
    tick;
    set(1, 'h30, 5, 0, 0, 0);
    tick;
    set(1, 'h30, 6, 0, 0, 0);
    tick;
    drain_all("t4");
    tick;
    c30 = 0;
    foreach (dlog[i]) if (dlog[i].a == 'h30) c30++;
    chk("t4_writes_0x30", c30, coal ? 1 : 2);
    chk("t4_total_writes", dlog.size(), coal ? 2 : 3);
    chk("t4_last_data", dlog.size() > 0 ? dlog[dlog.size()-1].d : '0, 6);
    set(1, 'h50, 1, 0, 0, 'h50);
    tick;
    set(1, 'h54, 2, 0, 0, 'h50);
    tick;
    set(1, 'h58, 3, 0, 0, 'h50);
    tick;
    bus.st_valid = 0;
    tick;
    #1;
    chk("t5_pre_we", bus.mem_we, 1);
    rst = 1'b1;
    #1;
    chk("t5_we_async", bus.mem_we, 0);
    chk("t5_empty_async", bus.empty, 1);
    chk("t5_hit_async", bus.ld_hit, 0);
    tick;
    rst = 1'b0;
    dlog.delete();
    bus.mem_ack = 1;
    repeat (4) tick;
    chk("t5_no_writes", dlog.size(), 0);
    set(1, 'h60, 1, 0, 0, 0);
    tick;
    set(1, 'h64, 2, 0, 0, 0);
    tick;
    set(1, 'h70, 7, 0, 1, 0);
    #1;
    chk("t6_blocked", bus.st_ready, 0);
    bus.mem_ack = 1;
    for (int n = 0; n < 10 && !(bus.empty && !bus.mem_we); n++) tick;
    #1;
    chk("t6_empty", bus.empty, 1);
    chk("t6_still_blocked", bus.st_ready, 0);
    bus.drain_req = 0;
    #1;
    chk("t6_resume", bus.st_ready, 1);
    tick;
    #1;
    chk("t6_accepted", bus.empty, 0);
    for (int i = 0; i < 3000; i++) begin
      set($urandom_range(0, 1), AW'('h80 + $urandom_range(0, 3)), $urandom, $urandom_range(0, 1),
          $urandom_range(0, 9) == 0, AW'('h80 + $urandom_range(0, 4)));
      tick;
    end
    drain_all("rand");
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
